sc_fetch_seq: RTL

SC_FETCH_SEQ -- requirements
Module: sc_fetch_seq

---
 rtl/sc_fetch_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sc_fetch_seq.sv
// Fetch/decode/execute sequencer: walks an instruction through FETCH, IR load,
// decode, ALU execute and write-back, with memory timeout and illegal-op faults.
module sc_fetch_seq #(
  parameter int DATAWIDTH_DECODEROP = 8,
  parameter int MEM_TIMEOUT         = 16
) (
  input  logic                           SC_FetchSEQ_CLOCK_50,
  input  logic                           SC_FetchSEQ_RESET_InHigh,
  input  logic                           SC_FetchSEQ_run_In,
  input  logic                           SC_FetchSEQ_clear_In,
  input  logic                           SC_FetchSEQ_memAck_In,
  input  logic [DATAWIDTH_DECODEROP-1:0] SC_FetchSEQ_irOps_In,
  input  logic                           SC_FetchSEQ_irBit13_In,
  output logic                           SC_FetchSEQ_memRdReq_Out,
  output logic                           SC_FetchSEQ_irLoad_OutLow,
  output logic [5:0]                     SC_FetchSEQ_aluOp_Out,
  output logic                           SC_FetchSEQ_aluSrcImm_Out,
  output logic                           SC_FetchSEQ_rfWe_Out,
  output logic                           SC_FetchSEQ_pcInc_Out,
  output logic                           SC_FetchSEQ_fault_Out,
  output logic [1:0]                     SC_FetchSEQ_faultCode_Out,
  output logic [2:0]                     SC_FetchSEQ_state_Out,
  output logic [15:0]                    SC_FetchSEQ_retired_Out
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH  = 3'b001,
    ST_LOADIR = 3'b010,
    ST_DECODE = 3'b011,
    ST_EXEC   = 3'b100,
    ST_WB     = 3'b101,
    ST_FAULT  = 3'b111
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic [5:0]        alu_op_q, alu_op_d;
  logic              alu_imm_q, alu_imm_d;
  logic              nop_pc_q, nop_pc_d;
  logic [15:0]       retired_q, retired_d;

  logic [1:0] ir_op;
  logic [5:0] ir_op3;
  logic       alu_vis;

  assign ir_op  = SC_FetchSEQ_irOps_In[DATAWIDTH_DECODEROP-1 -: 2];
  assign ir_op3 = SC_FetchSEQ_irOps_In[5:0];

  always_ff @(posedge SC_FetchSEQ_CLOCK_50 or posedge SC_FetchSEQ_RESET_InHigh) begin
    if (SC_FetchSEQ_RESET_InHigh) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      fault_code_q <= 2'b00;
      alu_op_q     <= 6'b000000;
      alu_imm_q    <= 1'b0;
      nop_pc_q     <= 1'b0;
      retired_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      fault_code_q <= fault_code_d;
      alu_op_q     <= alu_op_d;
      alu_imm_q    <= alu_imm_d;
      nop_pc_q     <= nop_pc_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    fault_code_d = fault_code_q;
    alu_op_d     = alu_op_q;
    alu_imm_d    = alu_imm_q;
    nop_pc_d     = 1'b0;
    retired_d    = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (SC_FetchSEQ_run_In) begin
          state_d = ST_FETCH;
          wait_d  = '0;
        end
      end
      ST_FETCH: begin
        // An acknowledge on the final wait cycle still counts as success.
        if (SC_FetchSEQ_memAck_In) begin
          state_d = ST_LOADIR;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = 2'b01;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_LOADIR: state_d = ST_DECODE;
      ST_DECODE: begin
        case (ir_op)
          2'b10: begin
            state_d   = ST_EXEC;
            alu_op_d  = ir_op3;
            alu_imm_d = SC_FetchSEQ_irBit13_In;
          end
          2'b00: begin
            // NOP pcInc is registered so it shows the cycle after DECODE.
            nop_pc_d  = 1'b1;
            retired_d = retired_q + 16'd1;
            state_d   = SC_FetchSEQ_run_In ? ST_FETCH : ST_IDLE;
            wait_d    = '0;
          end
          default: begin
            state_d      = ST_FAULT;
            fault_code_d = 2'b10;
          end
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        retired_d = retired_q + 16'd1;
        state_d   = SC_FetchSEQ_run_In ? ST_FETCH : ST_IDLE;
        wait_d    = '0;
      end
      ST_FAULT: begin
        if (SC_FetchSEQ_clear_In) begin
          state_d      = ST_IDLE;
          fault_code_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_vis = (state_q == ST_EXEC) || (state_q == ST_WB);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_alu_op
      assign SC_FetchSEQ_aluOp_Out[gi] = alu_vis & alu_op_q[gi];
    end
  endgenerate

  assign SC_FetchSEQ_aluSrcImm_Out = alu_vis & alu_imm_q;
  assign SC_FetchSEQ_memRdReq_Out  = (state_q == ST_FETCH);
  assign SC_FetchSEQ_irLoad_OutLow = (state_q != ST_LOADIR);
  assign SC_FetchSEQ_rfWe_Out      = (state_q == ST_WB);
  assign SC_FetchSEQ_pcInc_Out     = (state_q == ST_WB) | nop_pc_q;
  assign SC_FetchSEQ_fault_Out     = (state_q == ST_FAULT);
  assign SC_FetchSEQ_faultCode_Out = fault_code_q;
  assign SC_FetchSEQ_state_Out     = state_q;
  assign SC_FetchSEQ_retired_Out   = retired_q;

endmodule
